// File: rtl/reg_access_seq.sv
// Operand-fetch / write-back sequencer for a 4 x 16-bit register file with one shared port.
// Optional build macro SAME_SRC_SKIP_EN: when rs==rt the second read is skipped.
module reg_access_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [1:0]  instr_rs,
  input  logic [1:0]  instr_rt,
  input  logic [1:0]  instr_rd,
  input  logic        instr_wb,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic        op_valid,
  input  logic        res_valid,
  input  logic [15:0] res_data,
  output logic [1:0]  rf_index,
  output logic [15:0] rf_wdata,
  input  logic [15:0] rf_rdata,
  output logic        rf_ren,
  output logic        rf_wen
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    CAPA = 3'd2,
    RDB  = 3'd3,
    CAPB = 3'd4,
    EXEC = 3'd5,
    WB   = 3'd6
  } state_t;

  state_t     state_r;
  logic [1:0] rt_r;
  logic [1:0] rd_r;
  logic       wb_r;
`ifdef SAME_SRC_SKIP_EN
  logic [1:0] rs_r;
`endif

  // Sequencer state, latched instruction fields and every registered output.
  // Strobes are set on entry to their state and cleared on exit, so each is a
  // single-cycle flop pulse always preceded by a low cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      rt_r        <= 2'd0;
      rd_r        <= 2'd0;
      wb_r        <= 1'b0;
`ifdef SAME_SRC_SKIP_EN
      rs_r        <= 2'd0;
`endif
      instr_ready <= 1'b1;
      op_a        <= 16'h0000;
      op_b        <= 16'h0000;
      op_valid    <= 1'b0;
      rf_index    <= 2'd0;
      rf_wdata    <= 16'h0000;
      rf_ren      <= 1'b0;
      rf_wen      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (instr_valid) begin
            rt_r        <= instr_rt;
            rd_r        <= instr_rd;
            wb_r        <= instr_wb;
`ifdef SAME_SRC_SKIP_EN
            rs_r        <= instr_rs;
`endif
            rf_index    <= instr_rs;
            rf_ren      <= 1'b1;
            instr_ready <= 1'b0;
            state_r     <= RDA;
          end else begin
            state_r     <= IDLE;
          end
        end
        RDA: begin
          rf_ren  <= 1'b0;
          state_r <= CAPA;
        end
        CAPA: begin
          op_a <= rf_rdata;
`ifdef SAME_SRC_SKIP_EN
          if (rs_r == rt_r) begin
            op_b     <= rf_rdata;
            op_valid <= 1'b1;
            state_r  <= EXEC;
          end else begin
            rf_index <= rt_r;
            rf_ren   <= 1'b1;
            state_r  <= RDB;
          end
`else
          rf_index <= rt_r;
          rf_ren   <= 1'b1;
          state_r  <= RDB;
`endif
        end
        RDB: begin
          rf_ren  <= 1'b0;
          state_r <= CAPB;
        end
        CAPB: begin
          op_b     <= rf_rdata;
          op_valid <= 1'b1;
          state_r  <= EXEC;
        end
        EXEC: begin
          if (res_valid) begin
            op_valid <= 1'b0;
            if (wb_r) begin
              rf_wdata <= res_data;
              rf_index <= rd_r;
              rf_wen   <= 1'b1;
              state_r  <= WB;
            end else begin
              instr_ready <= 1'b1;
              state_r     <= IDLE;
            end
          end else begin
            state_r <= EXEC;
          end
        end
        WB: begin
          rf_wen      <= 1'b0;
          instr_ready <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          // Unreachable encoding: recover to a quiet idle.
          rf_ren      <= 1'b0;
          rf_wen      <= 1'b0;
          op_valid    <= 1'b0;
          instr_ready <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_seq.sv
// Self-checking bench for reg_access_seq: table-driven instructions against a
// register-file model, plus hand-written reset and back-to-back sequences.
module tb_reg_access_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  instr_rs, instr_rt, instr_rd;
  logic        instr_wb;
  logic [15:0] op_a, op_b;
  logic        op_valid;
  logic        res_valid;
  logic [15:0] res_data;
  logic [1:0]  rf_index;
  logic [15:0] rf_wdata;
  logic [15:0] rf_rdata = 16'h0000;
  logic        rf_ren, rf_wen;

  always #5 clk = ~clk;

  reg_access_seq dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_rs(instr_rs), .instr_rt(instr_rt), .instr_rd(instr_rd), .instr_wb(instr_wb),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .res_valid(res_valid), .res_data(res_data),
    .rf_index(rf_index), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .rf_ren(rf_ren), .rf_wen(rf_wen)
  );

  // Register-file model: acts on strobe rising edges, observed mid-cycle.
  logic [15:0] regs [4] = '{16'h1234, 16'h0005, 16'h0007, 16'h0000};
  int          ren_cnt = 0, wen_cnt = 0, overlap_cnt = 0, long_cnt = 0;
  logic        prev_ren = 1'b0, prev_wen = 1'b0;
  logic [1:0]  last_widx = 2'd0;
  logic [15:0] last_wdata = 16'h0000;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rf_ren === 1'b1 && rf_wen === 1'b1) overlap_cnt <= overlap_cnt + 1;
    if ((rf_ren === 1'b1 && prev_ren) || (rf_wen === 1'b1 && prev_wen)) long_cnt <= long_cnt + 1;
    if (rf_ren === 1'b1 && !prev_ren) begin
      ren_cnt  <= ren_cnt + 1;
      rf_rdata <= regs[rf_index];
    end
    if (rf_wen === 1'b1 && !prev_wen) begin
      wen_cnt          <= wen_cnt + 1;
      regs[rf_index]   <= rf_wdata;
      last_widx        <= rf_index;
      last_wdata       <= rf_wdata;
    end
    prev_ren <= (rf_ren === 1'b1);
    prev_wen <= (rf_wen === 1'b1);
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one instruction and watch it complete; k counts negedges after the transfer edge.
  task automatic run_instr(input logic [1:0] rs, input logic [1:0] rt, input logic [1:0] rd,
                           input logic wb, input logic [15:0] res, input int delay,
                           output int valid_at, output int ov_cycles, output int ready_at,
                           output logic [15:0] a, output logic [15:0] b, output logic stable);
    int ovc;
    valid_at = -1; ov_cycles = 0; ready_at = -1; a = 16'h0000; b = 16'h0000; stable = 1'b1;
    ovc = 0;
    @(negedge clk);
    instr_rs = rs; instr_rt = rt; instr_rd = rd; instr_wb = wb; instr_valid = 1'b1;
    for (int i = 0; i < 20 && instr_ready !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (op_valid === 1'b1) begin
        ovc++;
        if (ovc == 1) begin
          valid_at = k; a = op_a; b = op_b;
        end else if (op_a !== a || op_b !== b) begin
          stable = 1'b0;
        end
        res_valid = (ovc > delay);
        res_data  = res;
      end else begin
        res_valid = 1'b0;
      end
      if (instr_ready === 1'b1) begin
        ready_at = k;
        break;
      end
      @(negedge clk);
    end
    ov_cycles = ovc;
    res_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  rs, rt, rd;
    logic        wb;
    logic [15:0] res;
    int          delay;
    logic [15:0] exp_a, exp_b, exp_rd;
    int          exp_valid_at, exp_ready_at, exp_ren, exp_wen;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int          valid_at, ov_cycles, ready_at, base_ren, base_wen, base_ov, base_long, n;
    int          xt [3];
    logic [15:0] a, b;
    logic        stable;

    // rs rt rd wb res delay | a b R[rd] | valid_at ready_at ren wen
    vecs[0] = '{2'd1, 2'd2, 2'd3, 1'b1, 16'h000C, 0, 16'h0005, 16'h0007, 16'h000C, 5, 7, 2, 1};
    vecs[1] = '{2'd3, 2'd0, 2'd1, 1'b0, 16'hFFFF, 3, 16'h000C, 16'h1234, 16'h0005, 5, 9, 2, 0};
`ifdef SAME_SRC_SKIP_EN
    vecs[2] = '{2'd1, 2'd1, 2'd0, 1'b1, 16'hA5A5, 1, 16'h0005, 16'h0005, 16'hA5A5, 3, 6, 1, 1};
`else
    vecs[2] = '{2'd1, 2'd1, 2'd0, 1'b1, 16'hA5A5, 1, 16'h0005, 16'h0005, 16'hA5A5, 5, 8, 2, 1};
`endif
    vecs[3] = '{2'd0, 2'd3, 2'd2, 1'b1, 16'h0102, 2, 16'hA5A5, 16'h000C, 16'h0102, 5, 9, 2, 1};

    reset = 1'b1; instr_valid = 1'b0; res_valid = 1'b0; res_data = 16'h0000;
    instr_rs = 2'd0; instr_rt = 2'd0; instr_rd = 2'd0; instr_wb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_op_valid", {31'd0, op_valid}, 32'd0);
    check("rst_strobes", {30'd0, rf_ren, rf_wen}, 32'd0);
    check("rst_op_a", {16'd0, op_a}, 32'd0);
    check("rst_op_b", {16'd0, op_b}, 32'd0);
    check("rst_rf_index_wdata", {14'd0, rf_index, rf_wdata}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 4; v++) begin
      base_ren = ren_cnt; base_wen = wen_cnt;
      run_instr(vecs[v].rs, vecs[v].rt, vecs[v].rd, vecs[v].wb, vecs[v].res, vecs[v].delay,
                valid_at, ov_cycles, ready_at, a, b, stable);
      check($sformatf("v%0d_op_a", v), {16'd0, a}, {16'd0, vecs[v].exp_a});
      check($sformatf("v%0d_op_b", v), {16'd0, b}, {16'd0, vecs[v].exp_b});
      check($sformatf("v%0d_valid_at", v), valid_at, vecs[v].exp_valid_at);
      check($sformatf("v%0d_ov_cycles", v), ov_cycles, vecs[v].delay + 1);
      check($sformatf("v%0d_stable", v), {31'd0, stable}, 32'd1);
      check($sformatf("v%0d_ready_at", v), ready_at, vecs[v].exp_ready_at);
      check($sformatf("v%0d_ren_pulses", v), ren_cnt - base_ren, vecs[v].exp_ren);
      check($sformatf("v%0d_wen_pulses", v), wen_cnt - base_wen, vecs[v].exp_wen);
      check($sformatf("v%0d_reg_rd", v), {16'd0, regs[vecs[v].rd]}, {16'd0, vecs[v].exp_rd});
      if (vecs[v].wb) begin
        check($sformatf("v%0d_wen_index", v), {30'd0, last_widx}, {30'd0, vecs[v].rd});
        check($sformatf("v%0d_wen_data", v), {16'd0, last_wdata}, {16'd0, vecs[v].res});
      end
    end

    // Reset asserted while the second read strobe is high.
    @(negedge clk);
    instr_rs = 2'd1; instr_rt = 2'd2; instr_rd = 2'd3; instr_wb = 1'b1; instr_valid = 1'b1;
    for (int i = 0; i < 20 && instr_ready !== 1'b1; i++) @(negedge clk);
    base_wen = wen_cnt;
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_ren_in_rdb", {31'd0, rf_ren}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ren_dropped", {31'd0, rf_ren}, 32'd0);
    check("midrst_ready", {31'd0, instr_ready}, 32'd1);
    check("midrst_op_valid", {31'd0, op_valid}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_wen", wen_cnt - base_wen, 0);
    run_instr(2'd1, 2'd3, 2'd2, 1'b1, 16'h0011, 0, valid_at, ov_cycles, ready_at, a, b, stable);
    check("post_rst_op_a", {16'd0, a}, 32'h0005);
    check("post_rst_op_b", {16'd0, b}, 32'h000C);
    check("post_rst_ready_at", ready_at, 7);
    check("post_rst_reg", {16'd0, regs[2]}, 32'h0011);

    // Back-to-back: valid and res_valid held high across three instructions.
    base_ov = overlap_cnt; base_long = long_cnt; base_wen = wen_cnt; n = 0;
    @(negedge clk);
    instr_rs = 2'd0; instr_rt = 2'd1; instr_rd = 2'd3; instr_wb = 1'b1;
    res_data = 16'h0042; res_valid = 1'b1; instr_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (instr_ready === 1'b1 && instr_valid) begin
        xt[n] = cyc;
        n++;
        if (n == 3) break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    for (int i = 0; i < 20 && instr_ready !== 1'b1; i++) @(negedge clk);
    res_valid = 1'b0;
    check("b2b_transfers", n, 3);
    check("b2b_gap_1", xt[1] - xt[0], 7);
    check("b2b_gap_2", xt[2] - xt[1], 7);
    check("b2b_wen_pulses", wen_cnt - base_wen, 3);
    check("b2b_no_overlap", overlap_cnt - base_ov, 0);
    check("b2b_low_before_rise", long_cnt - base_long, 0);
    check("b2b_reg", {16'd0, regs[3]}, 32'h0042);
    check("all_no_overlap", overlap_cnt, 0);
    check("all_single_cycle_strobes", long_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
